// File: rtl/pll_sim_pkg.sv
// Shared types and helpers for the behavioural PLL simulation model.
package pll_sim_pkg;

  // Top-level lock/run sequencing states.
  typedef enum logic [1:0] {
    LOCKING,
    RUN,
    PDOWN
  } pll_state_e;

  // Highest number of output channels the model supports.
  localparam int unsigned MAX_OUT = 6;

  // Counter value that puts the first rising edge 'phase' cycles after lock.
  function automatic int unsigned start_cnt(input int unsigned div,
                                            input int unsigned phase);
    if (div == 0) begin
      return 0;
    end
    return (div - phase) % div;
  endfunction

endpackage

// File: rtl/pll_sim_divider.sv
// One output channel: wrap-at-divide counter plus registered clock output.
module pll_sim_divider #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  input  logic [CNT_W-1:0] high,
  input  logic [CNT_W-1:0] start,
  output logic             clkout
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  // Next counter value; wrap is explicit at div-1, never natural overflow.
  always_comb begin
    cnt_n = '0;
    if (load) begin
      cnt_n = start;
    end else if (run) begin
      cnt_n = (cnt == div - ONE) ? '0 : cnt + ONE;
    end
  end

  // Counter and output update together so the output tracks the new count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      clkout <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      clkout <= (load || run) && (cnt_n < high);
    end
  end

endmodule

// File: rtl/pll_sim_model.sv
// Behavioural PLL: lock sequencer plus NUM_OUT integer-divided output clocks.
module pll_sim_model
  import pll_sim_pkg::*;
#(
  parameter int unsigned                   NUM_OUT     = 1,
  parameter int unsigned                   CNT_W       = 8,
  parameter logic [NUM_OUT*CNT_W-1:0]      DIVIDE      = {NUM_OUT{CNT_W'(2)}},
  parameter logic [NUM_OUT*CNT_W-1:0]      HIGH_CNT    = {NUM_OUT{CNT_W'(1)}},
  parameter logic [NUM_OUT*CNT_W-1:0]      PHASE       = '0,
  parameter int unsigned                   LOCK_CYCLES = 16
) (
  input  logic               CLKIN1,
  input  logic               RST,
  input  logic               PWRDWN,
  output logic [NUM_OUT-1:0] CLKOUT,
  output logic               LOCKED
);

  localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);

  pll_state_e  state;
  pll_state_e  state_n;
  logic [31:0] lock_cnt;
  logic [31:0] lock_cnt_n;
  logic        load;
  logic        run;
  logic        locked_n;

  if (NUM_OUT < 1 || NUM_OUT > MAX_OUT) begin : g_bad_num_out
    $error("pll_sim_model: NUM_OUT=%0d outside 1..%0d", NUM_OUT, MAX_OUT);
  end

  if (LOCK_CYCLES == 0) begin : g_bad_lock
    $error("pll_sim_model: LOCK_CYCLES must be at least 1");
  end

  // Next state, lock counter and channel strobes; power-down beats lock completion.
  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    load       = 1'b0;
    run        = 1'b0;
    unique case (state)
      LOCKING: begin
        if (PWRDWN) begin
          state_n    = PDOWN;
          lock_cnt_n = '0;
        end else if (lock_cnt == LOCK_LAST) begin
          state_n    = RUN;
          lock_cnt_n = '0;
          load       = 1'b1;
        end else begin
          lock_cnt_n = lock_cnt + 32'd1;
        end
      end
      RUN: begin
        if (PWRDWN) begin
          state_n = PDOWN;
        end else begin
          run = 1'b1;
        end
      end
      PDOWN: begin
        lock_cnt_n = '0;
        if (!PWRDWN) begin
          state_n = LOCKING;
        end
      end
      default: begin
        state_n    = LOCKING;
        lock_cnt_n = '0;
      end
    endcase
    locked_n = load || run;
  end

  // Sequencer state, lock counter and registered LOCKED.
  always_ff @(posedge CLKIN1 or posedge RST) begin
    if (RST) begin
      state    <= LOCKING;
      lock_cnt <= '0;
      LOCKED   <= 1'b0;
    end else begin
      state    <= state_n;
      lock_cnt <= lock_cnt_n;
      LOCKED   <= locked_n;
    end
  end

  for (genvar n = 0; n < NUM_OUT; n++) begin : g_ch
    localparam int unsigned DIV = 32'(DIVIDE[n*CNT_W +: CNT_W]);
    localparam int unsigned HI  = 32'(HIGH_CNT[n*CNT_W +: CNT_W]);
    localparam int unsigned PH  = 32'(PHASE[n*CNT_W +: CNT_W]);
    localparam int unsigned S   = start_cnt(DIV, PH);

    if (DIV < 2) begin : g_bad_div
      $error("pll_sim_model: channel %0d DIVIDE=%0d below 2", n, DIV);
    end
    if (HI < 1 || HI >= DIV) begin : g_bad_high
      $error("pll_sim_model: channel %0d HIGH_CNT=%0d outside 1..DIVIDE-1", n, HI);
    end
    if (PH >= DIV) begin : g_bad_phase
      $error("pll_sim_model: channel %0d PHASE=%0d not below DIVIDE", n, PH);
    end

    pll_sim_divider #(
      .CNT_W(CNT_W)
    ) u_div (
      .clk   (CLKIN1),
      .rst   (RST),
      .load  (load),
      .run   (run),
      .div   (CNT_W'(DIV)),
      .high  (CNT_W'(HI)),
      .start (CNT_W'(S)),
      .clkout(CLKOUT[n])
    );
  end

endmodule

// File: tb/tb_pll_sim_model.sv
// Directed bench for pll_sim_model with six channels of differing divide/duty/phase.
module tb_pll_sim_model;

  logic       CLKIN1 = 1'b0;
  logic       RST    = 1'b1;
  logic       PWRDWN = 1'b0;
  logic [5:0] CLKOUT;
  logic       LOCKED;

  int total = 0;
  int bad   = 0;

  // Hand-derived output patterns from the lock edge (bit i = value i cycles after lock).
  logic [7:0]  pat [6];
  int unsigned per [6];
  logic [5:0]  prev_out;

  always #5 CLKIN1 = ~CLKIN1;

  // ch0 D4 H2 P0, ch1 D4 H2 P1, ch2 D5 H2 P0, ch3 D2 H1 P0, ch4 D8 H4 P0, ch5 D5 H3 P3
  pll_sim_model #(
    .NUM_OUT    (6),
    .CNT_W      (8),
    .DIVIDE     ({8'd5, 8'd8, 8'd2, 8'd5, 8'd4, 8'd4}),
    .HIGH_CNT   ({8'd3, 8'd4, 8'd1, 8'd2, 8'd2, 8'd2}),
    .PHASE      ({8'd3, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0}),
    .LOCK_CYCLES(16)
  ) dut (
    .CLKIN1(CLKIN1),
    .RST   (RST),
    .PWRDWN(PWRDWN),
    .CLKOUT(CLKOUT),
    .LOCKED(LOCKED)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_out(input int unsigned k);
    logic [5:0] e;
    e = '0;
    for (int unsigned c = 0; c < 6; c++) begin
      e[c] = pat[c][k % per[c]];
    end
    return e;
  endfunction

  // Sixteen edges from entry to LOCKING: unlocked and silent until the last one.
  task automatic lock_seq(input string tag);
    for (int e = 1; e <= 16; e++) begin
      @(negedge CLKIN1);
      check($sformatf("%s_locked_e%0d", tag, e), 32'(LOCKED), (e == 16) ? 32'd1 : 32'd0);
      check($sformatf("%s_clkout_e%0d", tag, e), 32'(CLKOUT),
            (e == 16) ? 32'(exp_out(0)) : 32'd0);
    end
    prev_out = CLKOUT;
  endtask

  // Running phase: every output follows its pattern; ch0/ch3/ch4 rise together every 8.
  task automatic run_seq(input string tag, input int unsigned n);
    logic [5:0] rise;
    for (int unsigned k = 1; k <= n; k++) begin
      @(negedge CLKIN1);
      check($sformatf("%s_clkout_k%0d", tag, k), 32'(CLKOUT), 32'(exp_out(k)));
      check($sformatf("%s_locked_k%0d", tag, k), 32'(LOCKED), 32'd1);
      rise = CLKOUT & ~prev_out;
      if (k % 8 == 0) begin
        check($sformatf("%s_coherent_k%0d", tag, k), 32'({rise[4], rise[0], rise[3]}), 32'd7);
      end
      prev_out = CLKOUT;
    end
  endtask

  initial begin
    pat[0] = 8'b0000_0011; per[0] = 4;
    pat[1] = 8'b0000_0110; per[1] = 4;
    pat[2] = 8'b0000_0011; per[2] = 5;
    pat[3] = 8'b0000_0001; per[3] = 2;
    pat[4] = 8'b0000_1111; per[4] = 8;
    pat[5] = 8'b0001_1001; per[5] = 5;
    prev_out = '0;

    // Reset state
    repeat (2) @(negedge CLKIN1);
    check("rst_locked", 32'(LOCKED), 32'd0);
    check("rst_clkout", 32'(CLKOUT), 32'd0);

    // First lock and steady run
    RST = 1'b0;
    lock_seq("lock1");
    run_seq("run1", 24);

    // One-cycle power-down pulse mid-run, then full relock
    PWRDWN = 1'b1;
    @(negedge CLKIN1);
    check("pd_locked", 32'(LOCKED), 32'd0);
    check("pd_clkout", 32'(CLKOUT), 32'd0);
    PWRDWN = 1'b0;
    @(negedge CLKIN1);
    check("pd_exit_locked", 32'(LOCKED), 32'd0);
    check("pd_exit_clkout", 32'(CLKOUT), 32'd0);
    lock_seq("relock1");
    run_seq("run2", 10);

    // Power-down arriving on the lock-completion edge keeps the PLL unlocked
    PWRDWN = 1'b1;
    @(negedge CLKIN1);
    PWRDWN = 1'b0;
    @(negedge CLKIN1);
    for (int e = 1; e <= 15; e++) begin
      @(negedge CLKIN1);
      check($sformatf("pdlock_pre_e%0d", e), 32'(LOCKED), 32'd0);
    end
    PWRDWN = 1'b1;
    @(negedge CLKIN1);
    check("pdlock_edge_locked", 32'(LOCKED), 32'd0);
    check("pdlock_edge_clkout", 32'(CLKOUT), 32'd0);
    for (int e = 1; e <= 3; e++) begin
      @(negedge CLKIN1);
      check($sformatf("pdlock_hold_e%0d", e), 32'(LOCKED), 32'd0);
    end
    PWRDWN = 1'b0;
    @(negedge CLKIN1);
    lock_seq("relock2");
    run_seq("run3", 7);

    // Asynchronous reset between edges while running
    check("pre_arst_locked", 32'(LOCKED), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_locked", 32'(LOCKED), 32'd0);
    check("arst_clkout", 32'(CLKOUT), 32'd0);
    @(negedge CLKIN1);
    RST = 1'b0;
    lock_seq("lock2");
    run_seq("run4", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
